// File: rtl/seq_divider.sv
// Unsigned iterative restoring divider: one quotient bit per clock behind a
// start/busy/done handshake; a zero divisor finishes early with div_by_zero set.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   t;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    t           = {r_q, q_q[WIDTH-1]};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // A zero divisor still spends one busy cycle in CALC so done lands at A+1.
          state_d = S_CALC;
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          zero_d  = (divisor == '0);
          cnt_d   = (divisor == '0) ? CW'(1) : CW'(WIDTH);
        end
      end
      S_CALC: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = q_q;
          dbz_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          // Partial remainder stays below the divisor, so WIDTH bits hold the difference.
          if (t >= {1'b0, d_q}) begin
            r_d = t[WIDTH-1:0] - d_q;
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = t[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient_d  = q_d;
            remainder_d = r_d;
            dbz_d       = 1'b0;
            state_d     = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider (WIDTH=8) against a queued
// scoreboard of expected quotient/remainder/div_by_zero results.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_q = '0;
  logic [7:0] last_r = '0;
  logic       last_z = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle (IDLE or DONE cycle).
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q = 8'hFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("quotient_held", 32'(quotient), 32'(last_q));
    check("remainder_held", 32'(remainder), 32'(last_r));
    check("dbz_held", 32'(div_by_zero), 32'(last_z));
  endtask

  // Counts remaining busy cycles up to the done pulse; returns in the done cycle.
  task automatic wait_done(input int exp_busy);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      check("busy_during_run", 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    check("busy_cycles", 32'(cyc), 32'(exp_busy));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("scoreboard_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("quotient", 32'(quotient), 32'(e.q));
      check("remainder", 32'(remainder), 32'(e.r));
      check("div_by_zero", 32'(div_by_zero), 32'(e.z));
      if (e.b != 8'd0) begin
        check("q_times_d_plus_r", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
        check("r_below_divisor", 32'(remainder < e.b), 32'd1);
      end
      last_q = e.q;
      last_r = e.r;
      last_z = e.z;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("done_low_idle", 32'(done), 32'd0);
      check("busy_low_idle", 32'(busy), 32'd0);
      check("quotient_stable", 32'(quotient), 32'(last_q));
      check("remainder_stable", 32'(remainder), 32'(last_r));
      check("dbz_stable", 32'(div_by_zero), 32'(last_z));
    end
  endtask

  task automatic full_op(input logic [7:0] a, input logic [7:0] b);
    start_op(a, b);
    wait_done((b == 8'd0) ? 1 : 8);
    idle_check(1);
  endtask

  initial begin
    logic [7:0] corners[6];
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    idle_check(2);

    // Basic run and boundary operands.
    full_op(8'd200, 8'd7);
    full_op(8'd5, 8'd9);
    full_op(8'd255, 8'd1);
    full_op(8'd0, 8'd3);
    full_op(8'd255, 8'd255);

    // Divide by zero, then a normal run clears the flag.
    full_op(8'd17, 8'd0);
    full_op(8'd10, 8'd3);

    // Start while busy is ignored; start in the done cycle is accepted.
    start_op(8'd100, 8'd3);
    repeat (2) @(negedge clk);
    dividend = 8'd9;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(5);
    start_op(8'd9, 8'd9);
    wait_done(8);
    idle_check(12);

    // Reset mid-run aborts without a done pulse.
    start_op(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    void'(sb.pop_back());
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    idle_check(12);
    full_op(8'd200, 8'd7);

    // Corner cross product, then random pairs with random idle gaps.
    corners = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        full_op(corners[i], corners[j]);
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      start_op(a, b);
      wait_done((b == 8'd0) ? 1 : 8);
      if ($urandom_range(0, 3) != 0) idle_check(int'($urandom_range(1, 3)));
    end
    idle_check(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
